router_a_seq: RTL and testbench
===============================

Name: router_a_seq

Overview:
- Sequencer for the register-file data-bus router.
- Drives the router's select lines (sel_data, sel_dira, sel_dirb, sel_write), its internal addresses CTL_A/CTL_B, and its WRITE_REQ.
- Arbitrates four command sources onto the single register-file port: bulk clear, host write, host read, and arithmetic-op writeback. Op writeback is gated by the arithmetic unit's READY, with a timeout.

Parameters:
- ADDRW, 5, register-file address width.
- DEPTH, 32, number of words zeroed by clear; legal range 1..2**ADDRW.
- TMOW, 8, timeout counter width. Timeout fires at count 2**TMOW-1.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CLR_REQ  in  1  request: zero words 0..DEPTH-1.
- EXT_WR  in  1  request: write DATA_IN to DIR_EXT.
- EXT_RD  in  1  request: read port B from DIR_EXT.
- OP_REQ  in  1  request: run an arithmetic op and write back RESULT.
- OP_DST  in  ADDRW  op destination address; latched on accept.
- OP_SRC  in  ADDRW  op source address; latched on accept.
- READY  in  1  arithmetic unit result valid.
- sel_data  out  2  router data select.
- sel_dira  out  1  router port-A address select.
- sel_dirb  out  1  router port-B address select.
- sel_write  out  2  router write-mode select.
- ctl_a  out  ADDRW  router CTL_A.
- ctl_b  out  ADDRW  router CTL_B.
- wr_req  out  1  router WRITE_REQ.
- op_go  out  1  one-cycle start pulse to the arithmetic unit.
- ack  out  1  one-cycle pulse the cycle after a request is accepted.
- rd_valid  out  1  port-B read data valid this cycle.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on command completion.
- err  out  1  sticky op-timeout flag.

Behaviour:
- States: IDLE, CLEAR, EXT_W, EXT_R, OP_ISSUE, OP_WAIT. State, ctl_a, ctl_b, counters and all pulses are registered. Router selects are decoded from the registered state.
- Reset (async, immediate): state IDLE; sel_data=1, sel_dira=0, sel_dirb=0, sel_write=2; ctl_a=0, ctl_b=0; wr_req, op_go, ack, rd_valid, done, err, busy all 0; counters 0.
- Reset mid-operation: the command is abandoned, and sel_write=2 takes effect immediately, so no write can occur.
- IDLE outputs: sel_write=2 (no write), sel_data=1, sel_dira=0, sel_dirb=0.
- IDLE arbitration, fixed priority CLR_REQ > EXT_WR > EXT_RD > OP_REQ:
  - Exactly one request is accepted per IDLE cycle; losers are ignored and must be held by the requester.
  - Requests are not sampled outside IDLE.
  - ack pulses in the first cycle of the new state.
- CLEAR:
  - Outputs: sel_data=2, sel_dira=0, sel_write=3; ctl_a counts 0..DEPTH-1, one word per cycle.
  - After the word DEPTH-1 cycle: go to IDLE, pulse done, clear err.
  - Duration: exactly DEPTH cycles.
- EXT_W: one cycle; sel_data=0, sel_dira=1, sel_write=3. Then IDLE, with done pulsing in the IDLE cycle.
- EXT_R: one cycle; sel_dirb=1, sel_write=2, rd_valid=1. Then IDLE with done.
- OP_ISSUE: one cycle; ctl_a=OP_DST and ctl_b=OP_SRC (latched at accept), sel_dira=0, sel_dirb=0, sel_data=1, sel_write=2, op_go=1.
- OP_WAIT:
  - Outputs: sel_data=1, sel_write=1, wr_req=1, so the router writes in the same cycle READY is high.
  - READY=1: go to IDLE, pulse done, timeout counter to 0.
  - Otherwise the counter increments. When it reaches 2**TMOW-1 with READY still 0: set err, go to IDLE, no write, done not pulsed.
  - READY high in the same cycle the timeout is reached counts as success; err is not set.
- ctl_a/ctl_b hold their last value outside CLEAR and OP states.
- READY is ignored outside OP_WAIT.
- busy = (state != IDLE).
- Every command returns to IDLE for at least one cycle before the next accept, so back-to-back commands are spaced by one IDLE cycle.

Test Plan:
1. Reset, then CLR_REQ=1 one cycle with DEPTH=32:
   - ack next cycle; 32 cycles of sel_write=3, sel_data=2, ctl_a=0..31.
   - Then done pulse, busy=0, register file all zero.
2. EXT_WR=1 and OP_REQ=1 asserted together with DIR_EXT=5, DATA_IN=24'h123456:
   - EXT_W wins: one cycle of sel_data=0, sel_dira=1, sel_write=3.
   - OP accepted only after an IDLE cycle; word 5 reads back 123456 via EXT_RD, with rd_valid=1 for one cycle and sel_dirb=1.
3. OP_REQ with OP_DST=7, OP_SRC=3, READY raised 4 cycles after op_go:
   - ctl_a=7, ctl_b=3; op_go for one cycle.
   - Router write occurs exactly in the READY cycle; done the next cycle; err=0.
4. OP_REQ with READY held 0, TMOW=8:
   - After 255 OP_WAIT cycles: err=1, state IDLE, no write to address OP_DST, no done.
   - A subsequent CLR_REQ clears err.
5. RST_N dropped in the middle of CLEAR, at ctl_a=10:
   - sel_write=2 immediately, all outputs at reset values, words 10..31 untouched.
   - Normal operation resumes after RST_N=1.

Source files
------------

// File: rtl/router_a_seq.sv
// Sequencer for the register-file data-bus router: arbitrates clear, host write,
// host read and arithmetic-op writeback onto the single register-file port.
module router_a_seq #(
    parameter int ADDRW = 5,
    parameter int DEPTH = 32,
    parameter int TMOW  = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR_REQ,
    input  logic             EXT_WR,
    input  logic             EXT_RD,
    input  logic             OP_REQ,
    input  logic [ADDRW-1:0] OP_DST,
    input  logic [ADDRW-1:0] OP_SRC,
    input  logic             READY,
    output logic [1:0]       sel_data,
    output logic             sel_dira,
    output logic             sel_dirb,
    output logic [1:0]       sel_write,
    output logic [ADDRW-1:0] ctl_a,
    output logic [ADDRW-1:0] ctl_b,
    output logic             wr_req,
    output logic             op_go,
    output logic             ack,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        EXT_W    = 3'd2,
        EXT_R    = 3'd3,
        OP_ISSUE = 3'd4,
        OP_WAIT  = 3'd5
    } state_t;

    localparam logic [ADDRW-1:0] LAST_WORD = ADDRW'(DEPTH - 1);
    localparam logic [TMOW-1:0]  TMO_MAX   = '1;

    state_t          state;
    logic [TMOW-1:0] tmo_cnt;
    logic [TMOW-1:0] tmo_nxt;

    assign tmo_nxt = tmo_cnt + TMOW'(1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            ctl_a   <= '0;
            ctl_b   <= '0;
            tmo_cnt <= '0;
            ack     <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            ack  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (CLR_REQ) begin
                        state <= CLEAR;
                        ctl_a <= '0;
                        ack   <= 1'b1;
                    end else if (EXT_WR) begin
                        state <= EXT_W;
                        ack   <= 1'b1;
                    end else if (EXT_RD) begin
                        state <= EXT_R;
                        ack   <= 1'b1;
                    end else if (OP_REQ) begin
                        state <= OP_ISSUE;
                        ctl_a <= OP_DST;
                        ctl_b <= OP_SRC;
                        ack   <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ctl_a == LAST_WORD) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        err   <= 1'b0;
                    end else begin
                        ctl_a <= ctl_a + ADDRW'(1);
                    end
                end
                EXT_W, EXT_R: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                OP_ISSUE: begin
                    state   <= OP_WAIT;
                    tmo_cnt <= '0;
                end
                OP_WAIT: begin
                    // READY wins over a timeout landing in the same cycle
                    if (READY) begin
                        state   <= IDLE;
                        done    <= 1'b1;
                        tmo_cnt <= '0;
                    end else if (tmo_nxt == TMO_MAX) begin
                        state   <= IDLE;
                        err     <= 1'b1;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Router controls follow the state register, so reset forces no-write at once
    always_comb begin
        sel_data  = 2'd1;
        sel_dira  = 1'b0;
        sel_dirb  = 1'b0;
        sel_write = 2'd2;
        wr_req    = 1'b0;
        op_go     = 1'b0;
        rd_valid  = 1'b0;
        case (state)
            CLEAR: begin
                sel_data  = 2'd2;
                sel_write = 2'd3;
            end
            EXT_W: begin
                sel_data  = 2'd0;
                sel_dira  = 1'b1;
                sel_write = 2'd3;
            end
            EXT_R: begin
                sel_dirb = 1'b1;
                rd_valid = 1'b1;
            end
            OP_ISSUE: op_go = 1'b1;
            OP_WAIT: begin
                sel_write = 2'd1;
                wr_req    = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_router_a_seq.sv
// Scoreboard bench for router_a_seq with a behavioural router/register-file model.
module tb_router_a_seq;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        CLR_REQ = 1'b0, EXT_WR = 1'b0, EXT_RD = 1'b0, OP_REQ = 1'b0, READY = 1'b0;
    logic [4:0]  OP_DST = '0, OP_SRC = '0;
    logic [1:0]  sel_data, sel_write;
    logic        sel_dira, sel_dirb, wr_req, op_go, ack, rd_valid, busy, done, err;
    logic [4:0]  ctl_a, ctl_b;

    logic [4:0]  dir_ext = '0;
    logic [23:0] data_in = '0, result = '0;
    logic [23:0] rf [32] = '{default: 24'hF0F0F0};

    router_a_seq #(.ADDRW(5), .DEPTH(32), .TMOW(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLR_REQ(CLR_REQ), .EXT_WR(EXT_WR), .EXT_RD(EXT_RD),
        .OP_REQ(OP_REQ), .OP_DST(OP_DST), .OP_SRC(OP_SRC), .READY(READY),
        .sel_data(sel_data), .sel_dira(sel_dira), .sel_dirb(sel_dirb), .sel_write(sel_write),
        .ctl_a(ctl_a), .ctl_b(ctl_b), .wr_req(wr_req), .op_go(op_go), .ack(ack),
        .rd_valid(rd_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    // Router model: sel_write 3 = unconditional write, 1 = write on WRITE_REQ & READY
    logic        write_now;
    logic [4:0]  waddr;
    logic [23:0] wdata;
    assign write_now = (sel_write == 2'd3) || (sel_write == 2'd1 && wr_req && READY);
    assign waddr = sel_dira ? dir_ext : ctl_a;
    assign wdata = (sel_data == 2'd0) ? data_in : (sel_data == 2'd2) ? 24'h0 : result;
    always @(posedge CLK) if (write_now) rf[waddr] <= wdata;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        int          cyc;
        logic [4:0]  flg;   // {ack, done, rd_valid, op_go, write}
        logic [1:0]  sd;
        logic [1:0]  dadb;
        logic [1:0]  sw;
        logic [4:0]  ca;
        logic [4:0]  cb;
        logic [23:0] rd;
        logic        er;
        logic        bsy;
    } snap_t;

    snap_t exq[$];
    string nmq[$];
    int    n_vec = 0, n_bad = 0;
    logic  err_q = 1'b0;

    function automatic snap_t mk(int c, logic [4:0] flg, logic [1:0] sd, logic [1:0] dadb,
                                 logic [1:0] sw, logic [4:0] ca, logic [4:0] cb,
                                 logic [23:0] rd, logic er, logic bsy);
        snap_t s;
        s.cyc = c; s.flg = flg; s.sd = sd; s.dadb = dadb; s.sw = sw;
        s.ca = ca; s.cb = cb; s.rd = rd; s.er = er; s.bsy = bsy;
        return s;
    endfunction

    function automatic snap_t snap_now();
        return mk(cyc, {ack, done, rd_valid, op_go, write_now}, sel_data, {sel_dira, sel_dirb},
                  sel_write, ctl_a, ctl_b, rd_valid ? rf[sel_dirb ? dir_ext : ctl_b] : 24'h0,
                  err, busy);
    endfunction

    function automatic void ex(string nm, snap_t s);
        exq.push_back(s);
        nmq.push_back(nm);
    endfunction

    // Monitor: any pulse, write or err change is an observable event to be matched
    always @(negedge CLK) begin
        snap_t g, e;
        string nm;
        g = snap_now();
        if ((|g.flg) || (err !== err_q)) begin
            n_vec++;
            if (exq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event cyc=%0d got=%h", cyc, g);
            end else begin
                e  = exq.pop_front();
                nm = nmq.pop_front();
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, g, e);
                end
            end
        end
        err_q = err;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_until(int t);
        while (cyc < t) tick();
    endtask

    task automatic check(string nm, logic [23:0] got, logic [23:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic check_reset(string nm);
        snap_t g, e;
        g = snap_now();
        e = mk(cyc, 5'b00000, 2'd1, 2'b00, 2'd2, 5'd0, 5'd0, 24'h0, 1'b0, 1'b0);
        n_vec++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", nm, g, e);
        end
    endtask

    function automatic void push_clear(int c, int nwords, logic er, logic [4:0] cb);
        for (int k = 0; k < nwords; k++)
            ex("clear_word", mk(c + 1 + k, (k == 0) ? 5'b10001 : 5'b00001, 2'd2, 2'b00, 2'd3,
                                5'(k), cb, 24'h0, er, 1'b1));
        if (nwords == 32)
            ex("clear_done", mk(c + 33, 5'b01000, 2'd1, 2'b00, 2'd2, 5'd31, cb, 24'h0, 1'b0, 1'b0));
    endfunction

    task automatic ext_write(logic [4:0] a, logic [23:0] d, logic [4:0] ca, logic [4:0] cb);
        int c = cyc;
        dir_ext = a; data_in = d; EXT_WR = 1'b1;
        ex("extw", mk(c + 1, 5'b10001, 2'd0, 2'b10, 2'd3, ca, cb, 24'h0, 1'b0, 1'b1));
        ex("extw_done", mk(c + 2, 5'b01000, 2'd1, 2'b00, 2'd2, ca, cb, 24'h0, 1'b0, 1'b0));
        tick(); EXT_WR = 1'b0;
        tick();
    endtask

    task automatic ext_read(logic [4:0] a, logic [23:0] d, logic [4:0] ca, logic [4:0] cb);
        int c = cyc;
        dir_ext = a; EXT_RD = 1'b1;
        ex("extr", mk(c + 1, 5'b10100, 2'd1, 2'b01, 2'd2, ca, cb, d, 1'b0, 1'b1));
        ex("extr_done", mk(c + 2, 5'b01000, 2'd1, 2'b00, 2'd2, ca, cb, 24'h0, 1'b0, 1'b0));
        tick(); EXT_RD = 1'b0;
        tick();
    endtask

    initial begin
        int c;
        int nz;
        #2 RST_N = 1'b0;
        #10 check_reset("reset_state");
        tick(); tick();
        RST_N = 1'b1;
        tick();

        // 1: full clear
        c = cyc;
        CLR_REQ = 1'b1;
        push_clear(c, 32, 1'b0, 5'd0);
        tick(); CLR_REQ = 1'b0;
        wait_until(c + 34);
        nz = 0;
        for (int i = 0; i < 32; i++) if (rf[i] != 24'h0) nz++;
        check("rf_cleared_count", 24'(nz), 24'h0);

        // 2: EXT_WR beats OP_REQ; op follows after one IDLE cycle; read back word 5
        c = cyc;
        dir_ext = 5'd5; data_in = 24'h123456; EXT_WR = 1'b1;
        OP_REQ = 1'b1; OP_DST = 5'd9; OP_SRC = 5'd2; result = 24'h0A0B0C;
        ex("prio_extw", mk(c + 1, 5'b10001, 2'd0, 2'b10, 2'd3, 5'd31, 5'd0, 24'h0, 1'b0, 1'b1));
        ex("prio_extw_done", mk(c + 2, 5'b01000, 2'd1, 2'b00, 2'd2, 5'd31, 5'd0, 24'h0, 1'b0, 1'b0));
        ex("prio_op_go", mk(c + 3, 5'b10010, 2'd1, 2'b00, 2'd2, 5'd9, 5'd2, 24'h0, 1'b0, 1'b1));
        ex("prio_op_wb", mk(c + 4, 5'b00001, 2'd1, 2'b00, 2'd1, 5'd9, 5'd2, 24'h0, 1'b0, 1'b1));
        ex("prio_op_done", mk(c + 5, 5'b01000, 2'd1, 2'b00, 2'd2, 5'd9, 5'd2, 24'h0, 1'b0, 1'b0));
        tick(); EXT_WR = 1'b0;
        tick();
        tick(); OP_REQ = 1'b0; OP_DST = '0; OP_SRC = '0;
        tick(); READY = 1'b1;
        tick(); READY = 1'b0;
        ext_read(5'd5, 24'h123456, 5'd9, 5'd2);

        // 3: op with READY four cycles after op_go; operands latched at accept
        c = cyc;
        OP_REQ = 1'b1; OP_DST = 5'd7; OP_SRC = 5'd3; result = 24'hABCDEF;
        ex("op_go", mk(c + 1, 5'b10010, 2'd1, 2'b00, 2'd2, 5'd7, 5'd3, 24'h0, 1'b0, 1'b1));
        ex("op_wb", mk(c + 5, 5'b00001, 2'd1, 2'b00, 2'd1, 5'd7, 5'd3, 24'h0, 1'b0, 1'b1));
        ex("op_done", mk(c + 6, 5'b01000, 2'd1, 2'b00, 2'd2, 5'd7, 5'd3, 24'h0, 1'b0, 1'b0));
        tick(); OP_REQ = 1'b0; OP_DST = '0; OP_SRC = '0;
        tick(); tick(); tick();
        tick(); READY = 1'b1;
        tick(); READY = 1'b0;
        wait_until(c + 8);

        // 4: op timeout after 255 OP_WAIT cycles, then clear drops err
        c = cyc;
        OP_REQ = 1'b1; OP_DST = 5'd12; OP_SRC = 5'd4; result = 24'h5A5A5A;
        ex("tmo_go", mk(c + 1, 5'b10010, 2'd1, 2'b00, 2'd2, 5'd12, 5'd4, 24'h0, 1'b0, 1'b1));
        ex("tmo_err", mk(c + 257, 5'b00000, 2'd1, 2'b00, 2'd2, 5'd12, 5'd4, 24'h0, 1'b1, 1'b0));
        tick(); OP_REQ = 1'b0;
        wait_until(c + 260);
        check("tmo_no_write", rf[12], 24'h0);
        check("op_word7", rf[7], 24'hABCDEF);
        check("op_word9", rf[9], 24'h0A0B0C);
        c = cyc;
        CLR_REQ = 1'b1;
        push_clear(c, 32, 1'b1, 5'd4);
        tick(); CLR_REQ = 1'b0;
        wait_until(c + 34);

        // 5: reset in the middle of a clear at word 10
        ext_write(5'd9, 24'h999999, 5'd31, 5'd4);
        ext_write(5'd10, 24'h111111, 5'd31, 5'd4);
        ext_write(5'd20, 24'h222222, 5'd31, 5'd4);
        c = cyc;
        CLR_REQ = 1'b1;
        push_clear(c, 10, 1'b0, 5'd4);
        tick(); CLR_REQ = 1'b0;
        wait_until(c + 11);
        #2 RST_N = 1'b0;
        #1 check_reset("reset_mid_clear");
        tick(); tick();
        RST_N = 1'b1;
        tick();
        ext_read(5'd10, 24'h111111, 5'd0, 5'd0);
        ext_read(5'd20, 24'h222222, 5'd0, 5'd0);
        ext_read(5'd9, 24'h000000, 5'd0, 5'd0);

        tick(); tick(); tick();
        while (exq.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL missing_event %s exp=%h", nmq.pop_front(), exq.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
